// File: rtl/wtbuf_native_pkg.sv
// Shared defaults for the write-through buffer between the cache front end and back end.
// Optional write merging is enabled by defining WTBUF_MERGE_EN.
package wtbuf_native_pkg;

    localparam int unsigned DEF_FE_ADDR_W = 32;
    localparam int unsigned DEF_FE_DATA_W = 32;
    localparam int unsigned DEF_DEPTH_W   = 3;

endpackage

// File: rtl/wtbuf_regfile.sv
// Entry storage for the write-through buffer: one synchronous write port with
// per-byte enables (used when merging) and one asynchronous read port.
module wtbuf_regfile #(
    parameter int unsigned DEPTH_W = 3,
    parameter int unsigned TAG_W   = 30,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned NBYTES = DATA_W / 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic               wmerge,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [NBYTES-1:0]  wstrb,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [TAG_W-1:0]   rtag,
    output logic [DATA_W-1:0]  rdata,
    output logic [NBYTES-1:0]  rstrb
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;

    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [NBYTES-1:0] strb_mem [DEPTH];

    // A merge keeps old bytes where the new strobe is clear and ORs the strobes.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[waddr]  <= wtag;
            strb_mem[waddr] <= wmerge ? (strb_mem[waddr] | wstrb) : wstrb;
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (!wmerge || wstrb[b]) begin
                    data_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rtag  = tag_mem[raddr];
    assign rdata = data_mem[raddr];
    assign rstrb = strb_mem[raddr];

endmodule

// File: rtl/wtbuf_native.sv
// Write-through buffer: FIFO of cache write requests feeding the back-end write channel.
// Define WTBUF_MERGE_EN to coalesce same-address pushes into the newest entry.
module wtbuf_native
    import wtbuf_native_pkg::*;
#(
    parameter int unsigned FE_ADDR_W = DEF_FE_ADDR_W,
    parameter int unsigned FE_DATA_W = DEF_FE_DATA_W,
    parameter int unsigned DEPTH_W   = DEF_DEPTH_W,
    localparam int unsigned FE_NBYTES = FE_DATA_W / 8,
    localparam int unsigned FE_BYTE_W = $clog2(FE_NBYTES),
    localparam int unsigned WADDR_W   = FE_ADDR_W - FE_BYTE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [WADDR_W-1:0]   push_addr,
    input  logic [FE_DATA_W-1:0] push_wdata,
    input  logic [FE_NBYTES-1:0] push_wstrb,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_W:0]     level,
    output logic                 write_valid,
    output logic [WADDR_W-1:0]   write_addr,
    output logic [FE_DATA_W-1:0] write_wdata,
    output logic [FE_NBYTES-1:0] write_wstrb,
    input  logic                 write_ready,
    output logic                 overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_W;

    logic [DEPTH_W-1:0] wr_ptr;
    logic [DEPTH_W-1:0] rd_ptr;
    logic               pop_c;
    logic               merge_c;
    logic               alloc_c;
    logic               drop_c;
    logic [DEPTH_W-1:0] waddr_c;

    assign empty       = (level == '0);
    assign full        = (level == (DEPTH_W+1)'(DEPTH));
    assign write_valid = !empty;
    assign pop_c       = write_valid && write_ready;

`ifdef WTBUF_MERGE_EN
    logic [WADDR_W-1:0] newest_addr;

    // With two or more entries the newest is never the one being presented or popped.
    assign merge_c = push && (level >= (DEPTH_W+1)'(2)) && (push_addr == newest_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            newest_addr <= '0;
        end else if (alloc_c) begin
            newest_addr <= push_addr;
        end
    end
`else
    assign merge_c = 1'b0;
`endif

    assign alloc_c = push && !full && !merge_c;
    assign drop_c  = push && full && !merge_c;
    assign waddr_c = merge_c ? (wr_ptr - DEPTH_W'(1)) : wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (alloc_c) begin
                wr_ptr <= wr_ptr + DEPTH_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + DEPTH_W'(1);
            end
            level <= level + (DEPTH_W+1)'(alloc_c) - (DEPTH_W+1)'(pop_c);
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    wtbuf_regfile #(
        .DEPTH_W (DEPTH_W),
        .TAG_W   (WADDR_W),
        .DATA_W  (FE_DATA_W)
    ) u_regfile (
        .clk    (clk),
        .we     (alloc_c || merge_c),
        .wmerge (merge_c),
        .waddr  (waddr_c),
        .wtag   (push_addr),
        .wdata  (push_wdata),
        .wstrb  (push_wstrb),
        .raddr  (rd_ptr),
        .rtag   (write_addr),
        .rdata  (write_wdata),
        .rstrb  (write_wstrb)
    );

endmodule

// File: tb/tb_wtbuf_native.sv
// Randomized and directed bench for wtbuf_native against a queue-based reference model.
// Follows WTBUF_MERGE_EN in its model when the macro is defined.
module tb_wtbuf_native;

    localparam int unsigned AW    = 30;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } ent_t;

    logic          clk;
    logic          reset;
    logic          push;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_wdata;
    logic [SW-1:0] push_wstrb;
    logic          full;
    logic          empty;
    logic [3:0]    level;
    logic          write_valid;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_wdata;
    logic [SW-1:0] write_wstrb;
    logic          write_ready;
    logic          overflow;

    ent_t q[$];
    bit   ovf_m;
    int   vectors;
    int   miscompares;

    wtbuf_native dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_addr   (push_addr),
        .push_wdata  (push_wdata),
        .push_wstrb  (push_wstrb),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .write_valid (write_valid),
        .write_addr  (write_addr),
        .write_wdata (write_wdata),
        .write_wstrb (write_wstrb),
        .write_ready (write_ready),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("level", 64'(level), 64'(q.size()));
        check("empty", 64'(empty), 64'(q.size() == 0));
        check("full", 64'(full), 64'(q.size() == DEPTH));
        check("write_valid", 64'(write_valid), 64'(q.size() != 0));
        check("overflow", 64'(overflow), 64'(ovf_m));
        if (q.size() != 0) begin
            check("write_addr", 64'(write_addr), 64'(q[0].addr));
            check("write_wdata", 64'(write_wdata), 64'(q[0].data));
            check("write_wstrb", 64'(write_wstrb), 64'(q[0].strb));
        end
    endtask

    // Check the current state, apply one cycle of inputs, then advance the model.
    task automatic step(input bit p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input bit rdy);
        bit   do_pop;
        bit   do_merge;
        ent_t e;
        check_outputs();
        push        = p;
        push_addr   = a;
        push_wdata  = d;
        push_wstrb  = s;
        write_ready = rdy;
        @(posedge clk);
        do_pop   = (q.size() != 0) && rdy;
        do_merge = 1'b0;
`ifdef WTBUF_MERGE_EN
        do_merge = p && (q.size() >= 2) && (q[q.size()-1].addr == a);
`endif
        if (p) begin
            if (do_merge) begin
                e = q[q.size()-1];
                for (int b = 0; b < int'(SW); b++) begin
                    if (s[b]) e.data[8*b +: 8] = d[8*b +: 8];
                end
                e.strb = e.strb | s;
                q[q.size()-1] = e;
            end else if (q.size() < DEPTH) begin
                e.addr = a;
                e.data = d;
                e.strb = s;
                q.push_back(e);
            end else begin
                ovf_m = 1'b1;
            end
        end
        if (do_pop) void'(q.pop_front());
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, '0, '0, '0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < int'(DEPTH) + 1; i++) idle(1'b1);
    endtask

    // Assert reset between clock edges and check the cleared state before the next edge.
    task automatic async_reset();
        push        = 1'b0;
        write_ready = 1'b0;
        #2;
        reset = 1'b1;
        q.delete();
        ovf_m = 1'b0;
        #1;
        check_outputs();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ovf_m       = 1'b0;
        reset       = 1'b1;
        push        = 1'b0;
        push_addr   = '0;
        push_wdata  = '0;
        push_wstrb  = '0;
        write_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;

        // Single write held while stalled, then accepted.
        step(1'b1, AW'('h10), 32'hAABBCCDD, 4'hF, 1'b0);
        repeat (5) idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to full, overflow on the ninth push, drain in order.
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, AW'(32'h100 + i), 32'hC0DE_0000 + i, 4'hF, 1'b0);
        step(1'b1, AW'('h1FF), 32'hDEADBEEF, 4'hF, 1'b0);
        drain();

        // Full with simultaneous push and pop: push dropped, level falls to 7.
        async_reset();
        for (int i = 0; i < int'(DEPTH); i++) step(1'b1, AW'(32'h200 + i), 32'h5A5A_0000 + i, 4'h3, 1'b0);
        step(1'b1, AW'('h2FF), 32'h12345678, 4'hF, 1'b1);
        idle(1'b0);
        drain();

        // Steady state at level 3 with pointer wrap.
        async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, AW'(32'h300 + i), 32'h3000 + i, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, AW'(32'h310 + i), 32'h3100 + i, 4'hF, 1'b1);
        drain();

        // Asynchronous reset while stalled at level 5.
        for (int i = 0; i < 5; i++) step(1'b1, AW'(32'h400 + i), 32'h4000 + i, 4'hF, 1'b0);
        idle(1'b0);
        async_reset();
        idle(1'b0);

        // Same-address pushes: merge at level 2 (when enabled), allocate at level 1.
        step(1'b1, AW'('h50), 32'h0000_0050, 4'hF, 1'b0);
        step(1'b1, AW'('h60), 32'h0000_1111, 4'h3, 1'b0);
        step(1'b1, AW'('h60), 32'h2222_0000, 4'hC, 1'b0);
        idle(1'b0);
        drain();
        step(1'b1, AW'('h60), 32'h0000_1111, 4'h3, 1'b0);
        step(1'b1, AW'('h60), 32'h2222_0000, 4'hC, 1'b0);
        idle(1'b0);
        drain();

        // Random traffic over a small address set so merges and overflows occur.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 60), AW'($urandom_range(0, 3)), DW'($urandom()),
                 SW'($urandom_range(0, 15)), ($urandom_range(0, 99) < 45));
        end
        drain();
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wtbuf_native.md
WTBUF_NATIVE -- requirements
Module: wtbuf_native

Interface
REQ-001 SHALL have parameter FE_ADDR_W, default 32, front-end byte address width.
REQ-002 SHALL have parameter FE_DATA_W, default 32, word width; FE_NBYTES=FE_DATA_W/8 and FE_BYTE_W=$clog2(FE_NBYTES) are derived.
REQ-003 SHALL have parameter DEPTH_W, default 3, log2 of entry count (DEPTH=2**DEPTH_W).
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have ports push (in, 1), push_addr (in, FE_ADDR_W-FE_BYTE_W), push_wdata (in, FE_DATA_W) and push_wstrb (in, FE_NBYTES), forming the cache-side write request.
REQ-007 SHALL have ports full (out, 1), empty (out, 1) and level (out, DEPTH_W+1), giving occupancy status.
REQ-008 SHALL have ports write_valid (out, 1), write_addr (out, FE_ADDR_W-FE_BYTE_W), write_wdata (out, FE_DATA_W), write_wstrb (out, FE_NBYTES) and write_ready (in, 1), forming the back-end write-channel request.
REQ-009 SHALL have port overflow (out, 1), a sticky flag set when a push is dropped.

Function
REQ-010 SHALL be a DEPTH-entry FIFO of {addr, wdata, wstrb}, with write pointer wr_ptr and read pointer rd_ptr, each DEPTH_W bits wide and wrapping modulo DEPTH.
REQ-011 SHALL compute empty as (level==0) and full as (level==DEPTH), both purely combinational from level.
REQ-012 SHALL drive write_valid = !empty, with write_addr/wdata/wstrb presenting the entry at rd_ptr combinationally (first-word fall-through); push to write_valid latency is 1 cycle.
REQ-013 SHALL hold write_* stable while write_valid && !write_ready.
REQ-014 SHALL pop (rd_ptr+1, level-1) on a cycle with write_valid && write_ready.
REQ-015 SHALL accept a push when push && !full, storing it at wr_ptr and incrementing wr_ptr and level.
REQ-016 SHALL, on simultaneous accepted push and pop, leave level unchanged while advancing both pointers.
REQ-017 SHALL, on push while full, drop the push even if a pop occurs in the same cycle, set overflow, and leave all contents unchanged.
REQ-018 SHALL ignore write_ready while empty, with no pointer change.
REQ-019 SHALL never let level exceed DEPTH or fall below 0.

Reset
REQ-020 SHALL, when reset is asserted (including mid-transfer), immediately clear wr_ptr, rd_ptr, level and overflow, discarding pending entries, so that empty=1, full=0, level=0, write_valid=0 and overflow=0.
REQ-021 SHALL leave the entry storage unreset; write_addr/wdata/wstrb are don't-care while write_valid=0.

Configuration
REQ-022 SHALL, with macro WTBUF_MERGE_EN defined, merge an accepted push into the newest entry (wr_ptr-1) instead of allocating, when level>=2, push_addr equals that entry's addr, and no pop of that entry occurs this cycle; merged bytes take push_wdata where push_wstrb is 1, wstrb becomes the OR of old and new, and level/wr_ptr are unchanged.
REQ-023 SHALL never merge into the entry currently presented at rd_ptr, guaranteeing REQ-013.
REQ-024 SHALL, without WTBUF_MERGE_EN, allocate a new entry on every push; a merge-eligible push while full is then dropped per REQ-017, whereas with the macro it is merged.

Structure
REQ-025 SHALL take the write-policy constants and shared width definitions from the common cache header iob-cache.vh; no new shared types are introduced.
REQ-026 SHALL contain one sub-module, wtbuf_regfile: DEPTH x (FE_ADDR_W-FE_BYTE_W+FE_DATA_W+FE_NBYTES) storage with 1 synchronous write port, per-byte write enable for merging, and 1 asynchronous read port.
REQ-027 SHALL instantiate wtbuf_native upstream of back_end_native, with write_* connected one-to-one; the cache controller uses empty to order a line replacement after pending write-throughs.

Verification
REQ-028 SHALL cover: push addr=0x10 wdata=0xAABBCCDD wstrb=0xF with write_ready=0 -> write_valid=1 the next cycle with the same data held for 5 cycles; write_ready=1 -> empty=1 the following cycle.
REQ-029 SHALL cover: DEPTH_W=3, 8 pushes with no ready -> full=1, level=8; 9th push -> dropped, overflow=1; drain -> all 8 entries appear in order.
REQ-030 SHALL cover: full FIFO with simultaneous push and pop -> push dropped, level=7, overflow=1.
REQ-031 SHALL cover: level=3 with continuous push and pop for 20 cycles -> level stays 3, pointers wrap, output order preserved.
REQ-032 SHALL cover: reset asserted asynchronously mid-stall at level=5 -> write_valid=0, level=0 and overflow=0 before the next clock edge.
REQ-033 SHALL cover, with WTBUF_MERGE_EN: at level=2 push addr=A wstrb=0x3 data=0x1111, then push addr=A wstrb=0xC data=0x2222_0000 -> level stays 2, the entry pops as 0x2222_1111 with wstrb=0xF; the same sequence at level=1 -> allocates a new entry.
